// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch frame scheduler.
//   sched_state_e : scheduler FSM states
//   DEF_*         : default parameter values used by pitch_frame_scheduler
//   cnt_width()   : bit width needed to hold a count of 0..max_val
package pitch_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    STREAM   = 2'd1,
    BUSY     = 2'd2,
    FLUSH    = 2'd3
  } sched_state_e;

  localparam int DEF_SIG_WIDTH      = 9;
  localparam int DEF_WIDTH          = 32;
  localparam int DEF_WINDOW_SIZE    = 500;
  localparam int DEF_HOP_SIZE       = 250;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous holding FIFO for samples that arrive while the estimator is busy.
//   clk_in, rst_in : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data: write request / data (ignored when full unless popping too)
//   pop            : read request (ignored when empty)
//   pop_data       : head word, read straight from the storage registers
//   full, empty    : occupancy flags
module sample_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pitch_frame_scheduler.sv
// Feeds a windowed pitch estimator with samples, starting a new estimation
// frame every HOP_SIZE samples once WINDOW_SIZE samples have been delivered.
// Samples arriving while the estimator works are held in a FIFO and drained
// once the result (or a timeout) arrives.
//   clk_in, rst_in       : clock, synchronous active-high reset
//   enable_in            : scheduling enable
//   sample_in(_valid)    : incoming sample stream
//   est_sig_out(_valid)  : registered sample stream to the estimator
//   est_start_out        : frame-start pulse (first BUSY cycle)
//   est_rst_out          : estimator recovery reset after a timeout
//   est_f_in(_valid_in)  : estimator frequency result
//   pitch_out, pitch_valid_out, voiced_out : latched result, update pulse, nonzero flag
//   overflow_out, timeout_out : sticky error flags
//   frames_out           : completed-frame count (wraps)
module pitch_frame_scheduler
  import pitch_pkg::*;
#(
  parameter int SIG_WIDTH      = DEF_SIG_WIDTH,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int WINDOW_SIZE    = DEF_WINDOW_SIZE,
  parameter int HOP_SIZE       = DEF_HOP_SIZE,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 enable_in,
  input  logic [SIG_WIDTH-1:0] sample_in,
  input  logic                 sample_in_valid,
  output logic [SIG_WIDTH-1:0] est_sig_out,
  output logic                 est_sig_valid_out,
  output logic                 est_start_out,
  output logic                 est_rst_out,
  input  logic [WIDTH-1:0]     est_f_in,
  input  logic                 est_f_valid_in,
  output logic [WIDTH-1:0]     pitch_out,
  output logic                 pitch_valid_out,
  output logic                 voiced_out,
  output logic                 overflow_out,
  output logic                 timeout_out,
  output logic [15:0]          frames_out
);

  localparam int FILL_W = cnt_width(WINDOW_SIZE);
  localparam int HOP_W  = cnt_width(HOP_SIZE);
  localparam int BUSY_W = cnt_width(TIMEOUT_CYCLES - 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW_SIZE);
  localparam logic [HOP_W-1:0]  HOP_FULL  = HOP_W'(HOP_SIZE);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT_CYCLES - 1);

  sched_state_e state;
  sched_state_e state_nx;

  logic [FILL_W-1:0]    fill_count;
  logic [HOP_W-1:0]     hop_count;
  logic [BUSY_W-1:0]    busy_count;
  logic                 hop_ready;
  logic                 deliver_direct;
  logic                 deliver;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [SIG_WIDTH-1:0] fifo_data;
  logic                 frame_start;
  logic                 frame_timeout;
  logic                 take_result;

  sample_fifo #(
    .WIDTH (SIG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (sample_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Counters are registered, so this is true in the cycle the hop-completing
  // sample is on est_sig_out; that cycle already routes new samples to the FIFO
  // and the start pulse lands one cycle later with est_sig_valid_out low.
  // hop_count saturates, so equality stands in for ">= HOP_SIZE".
  assign hop_ready = (fill_count == FILL_FULL) && (hop_count == HOP_FULL);
  assign deliver   = deliver_direct || fifo_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= DISABLED;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    deliver_direct = 1'b0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    frame_start    = 1'b0;
    frame_timeout  = 1'b0;
    take_result    = 1'b0;
    unique case (state)
      DISABLED: begin
        if (enable_in) state_nx = STREAM;
      end
      STREAM: begin
        if (hop_ready) begin
          state_nx    = BUSY;
          frame_start = 1'b1;
          fifo_push   = sample_in_valid;
        end else if (!enable_in) begin
          state_nx = DISABLED;
        end else begin
          deliver_direct = sample_in_valid;
        end
      end
      BUSY: begin
        fifo_push = sample_in_valid;
        if (est_f_valid_in) begin
          take_result = 1'b1;
          state_nx    = FLUSH;
        end else if (busy_count == BUSY_LAST) begin
          frame_timeout = 1'b1;
          state_nx      = FLUSH;
        end
      end
      FLUSH: begin
        // A pending hop waits for the FIFO to drain; once empty, a new sample
        // can bypass the FIFO because nothing older is queued ahead of it.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          fifo_push = sample_in_valid;
        end else if (hop_ready) begin
          state_nx    = BUSY;
          frame_start = 1'b1;
          fifo_push   = sample_in_valid;
        end else if (enable_in) begin
          state_nx       = STREAM;
          deliver_direct = sample_in_valid;
        end else begin
          state_nx = DISABLED;
        end
      end
      default: state_nx = DISABLED;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      est_sig_out       <= '0;
      est_sig_valid_out <= 1'b0;
      est_start_out     <= 1'b0;
      est_rst_out       <= 1'b0;
      pitch_out         <= '0;
      pitch_valid_out   <= 1'b0;
      voiced_out        <= 1'b0;
      overflow_out      <= 1'b0;
      timeout_out       <= 1'b0;
      frames_out        <= '0;
      fill_count        <= '0;
      hop_count         <= '0;
      busy_count        <= '0;
    end else begin
      est_start_out     <= frame_start;
      est_rst_out       <= frame_timeout;
      pitch_valid_out   <= take_result;
      est_sig_valid_out <= deliver;

      if (deliver_direct) begin
        est_sig_out <= sample_in;
      end else if (fifo_pop) begin
        est_sig_out <= fifo_data;
      end

      if (frame_timeout) begin
        fill_count  <= '0;
        hop_count   <= '0;
        timeout_out <= 1'b1;
      end else if (frame_start) begin
        hop_count <= '0;
      end else if (deliver) begin
        if (fill_count != FILL_FULL) fill_count <= fill_count + 1'b1;
        if (hop_count != HOP_FULL)   hop_count  <= hop_count + 1'b1;
      end

      if (take_result) begin
        pitch_out  <= est_f_in;
        voiced_out <= (est_f_in != '0);
        frames_out <= frames_out + 16'd1;
      end

      if (state == BUSY) begin
        busy_count <= busy_count + 1'b1;
      end else begin
        busy_count <= '0;
      end

      if (fifo_push && fifo_full && !fifo_pop) begin
        overflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pitch_frame_scheduler.sv
module tb_pitch_frame_scheduler;

  localparam int SW = 9;
  localparam int PW = 32;

  logic          clk;
  logic          rst_in;
  logic          enable_in;
  logic [SW-1:0] sample_in;
  logic          sample_in_valid;
  logic [SW-1:0] est_sig_out;
  logic          est_sig_valid_out;
  logic          est_start_out;
  logic          est_rst_out;
  logic [PW-1:0] est_f_in;
  logic          est_f_valid_in;
  logic [PW-1:0] pitch_out;
  logic          pitch_valid_out;
  logic          voiced_out;
  logic          overflow_out;
  logic          timeout_out;
  logic [15:0]   frames_out;

  pitch_frame_scheduler #(
    .SIG_WIDTH      (SW),
    .WIDTH          (PW),
    .WINDOW_SIZE    (8),
    .HOP_SIZE       (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .enable_in         (enable_in),
    .sample_in         (sample_in),
    .sample_in_valid   (sample_in_valid),
    .est_sig_out       (est_sig_out),
    .est_sig_valid_out (est_sig_valid_out),
    .est_start_out     (est_start_out),
    .est_rst_out       (est_rst_out),
    .est_f_in          (est_f_in),
    .est_f_valid_in    (est_f_valid_in),
    .pitch_out         (pitch_out),
    .pitch_valid_out   (pitch_valid_out),
    .voiced_out        (voiced_out),
    .overflow_out      (overflow_out),
    .timeout_out       (timeout_out),
    .frames_out        (frames_out)
  );

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];
  logic [PW-1:0] pitch_q[$];
  logic [SW-1:0] exp_v;
  logic [PW-1:0] exp_p;

  int cyc = 0;
  int dlv_cnt = 0;
  int start_cnt = 0;
  int rst_pulse_cnt = 0;
  int pv_cnt = 0;
  int last_start_dlv = 0;
  int prev_start_dlv = 0;
  int start_cyc = 0;
  int rst_cyc = 0;
  int rst_dlv = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard side: every delivery and every pitch update is matched against
  // the expectations queued when the stimulus was driven.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_in !== 1'b1) begin
        if (est_sig_valid_out === 1'b1) begin
          dlv_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sig_unexpected got %0d required none", est_sig_out);
          end else begin
            exp_v = exp_q.pop_front();
            if (est_sig_out !== exp_v) begin
              errors++;
              $display("FAIL sig_value got %0d required %0d", est_sig_out, exp_v);
            end
          end
        end
        if (est_start_out === 1'b1) begin
          start_cnt++;
          prev_start_dlv = last_start_dlv;
          last_start_dlv = dlv_cnt;
          start_cyc = cyc;
          checks++;
          if (est_sig_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL start_with_valid got %b required 0", est_sig_valid_out);
          end
        end
        if (est_rst_out === 1'b1) begin
          rst_pulse_cnt++;
          rst_cyc = cyc;
          rst_dlv = dlv_cnt;
        end
        if (pitch_valid_out === 1'b1) begin
          pv_cnt++;
          checks++;
          if (pitch_q.size() == 0) begin
            errors++;
            $display("FAIL pitch_unexpected got %h required none", pitch_out);
          end else begin
            exp_p = pitch_q.pop_front();
            if (pitch_out !== exp_p || voiced_out !== (exp_p != '0)) begin
              errors++;
              $display("FAIL pitch_value got %h/%b required %h/%b",
                       pitch_out, voiced_out, exp_p, (exp_p != '0));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [SW-1:0] v, input bit expect_out);
    @(posedge clk); #1;
    sample_in       = v;
    sample_in_valid = 1'b1;
    if (expect_out) exp_q.push_back(v);
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
  endtask

  task automatic send_result(input logic [PW-1:0] f, input bit expect_out);
    @(posedge clk); #1;
    est_f_in       = f;
    est_f_valid_in = 1'b1;
    if (expect_out) pitch_q.push_back(f);
    @(posedge clk); #1;
    est_f_valid_in = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int waited);
    int k;
    waited = -1;
    k = 0;
    while (waited < 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (est_start_out === 1'b1) waited = k;
    end
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; enable_in = 1'b0; sample_in = '0; sample_in_valid = 1'b0;
    est_f_in = '0; est_f_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({est_sig_out, est_sig_valid_out, est_start_out, est_rst_out} !== '0) begin
      errors++;
      $display("FAIL reset_est got %h required 0", {est_sig_out, est_sig_valid_out, est_start_out, est_rst_out});
    end
    checks++;
    if ({pitch_out, pitch_valid_out, voiced_out} !== '0) begin
      errors++;
      $display("FAIL reset_pitch got %h required 0", {pitch_out, pitch_valid_out, voiced_out});
    end
    checks++;
    if ({overflow_out, timeout_out, frames_out} !== '0) begin
      errors++;
      $display("FAIL reset_flags got %h required 0", {overflow_out, timeout_out, frames_out});
    end
    @(posedge clk); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_stream;
    int w;
    enable_in = 1'b1;
    idle(2);
    for (int i = 1; i <= 8; i++) begin
      send_sample(SW'(i), 1'b1);
      if (i == 1) begin
        @(negedge clk);
        checks++;
        if (est_sig_valid_out !== 1'b1 || est_sig_out !== SW'(1)) begin
          errors++;
          $display("FAIL stream_latency got %b/%0d required 1/1", est_sig_valid_out, est_sig_out);
        end
      end
    end
    wait_start(10, w);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL first_start_delay got %0d required 2", w);
    end
    checks++;
    if (start_cnt !== 1 || last_start_dlv !== 8) begin
      errors++;
      $display("FAIL first_start_count got %0d@%0d required 1@8", start_cnt, last_start_dlv);
    end
  endtask

  task automatic test_result;
    int w;
    for (int i = 9; i <= 11; i++) send_sample(SW'(i), 1'b1);
    send_result(32'h0064_0000, 1'b1);
    @(negedge clk);
    checks++;
    if (pitch_valid_out !== 1'b1 || pitch_out !== 32'h0064_0000 || voiced_out !== 1'b1) begin
      errors++;
      $display("FAIL result_latch got %b/%h/%b required 1/00640000/1", pitch_valid_out, pitch_out, voiced_out);
    end
    checks++;
    if (frames_out !== 16'd1) begin
      errors++;
      $display("FAIL frames_one got %0d required 1", frames_out);
    end
    idle(8);
    checks++;
    if (exp_q.size() !== 0 || dlv_cnt !== 11) begin
      errors++;
      $display("FAIL flush_three got %0d/%0d required 0/11", exp_q.size(), dlv_cnt);
    end
    send_sample(SW'(12), 1'b1);
    wait_start(10, w);
    checks++;
    if (w !== 2 || start_cnt !== 2) begin
      errors++;
      $display("FAIL second_start got %0d/%0d required 2/2", w, start_cnt);
    end
    checks++;
    if (last_start_dlv - prev_start_dlv !== 4) begin
      errors++;
      $display("FAIL second_start_gap got %0d required 4", last_start_dlv - prev_start_dlv);
    end
  endtask

  task automatic test_overflow;
    int w;
    for (int i = 0; i < 6; i++) begin
      send_sample(SW'(13 + i), (i < 4));
      if (i == 3) begin
        @(negedge clk);
        checks++;
        if (overflow_out !== 1'b0) begin
          errors++;
          $display("FAIL overflow_at_full got %b required 0", overflow_out);
        end
      end
      if (i == 4) begin
        @(negedge clk);
        checks++;
        if (overflow_out !== 1'b1) begin
          errors++;
          $display("FAIL overflow_drop got %b required 1", overflow_out);
        end
      end
    end
    send_result(32'h0032_8000, 1'b1);
    @(negedge clk);
    checks++;
    if (frames_out !== 16'd2) begin
      errors++;
      $display("FAIL frames_two got %0d required 2", frames_out);
    end
    // Four drained samples complete the hop with the FIFO empty: straight to BUSY.
    wait_start(30, w);
    checks++;
    if (w < 0 || start_cnt !== 3) begin
      errors++;
      $display("FAIL flush_start got %0d/%0d required seen/3", w, start_cnt);
    end
    checks++;
    if (last_start_dlv - prev_start_dlv !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL flush_four got %0d/%0d required 4/0", last_start_dlv - prev_start_dlv, exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int w;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (est_rst_out === 1'b1) seen = 1'b1;
    end
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_wait got none required est_rst_out");
    end
    checks++;
    if (rst_cyc - start_cyc !== 64) begin
      errors++;
      $display("FAIL timeout_span got %0d required 64", rst_cyc - start_cyc);
    end
    checks++;
    if (timeout_out !== 1'b1 || pitch_out !== 32'h0032_8000) begin
      errors++;
      $display("FAIL timeout_flags got %b/%h required 1/00328000", timeout_out, pitch_out);
    end
    idle(3);
    checks++;
    if (rst_pulse_cnt !== 1) begin
      errors++;
      $display("FAIL est_rst_pulses got %0d required 1", rst_pulse_cnt);
    end
    for (int i = 19; i <= 25; i++) send_sample(SW'(i), 1'b1);
    idle(4);
    checks++;
    if (start_cnt !== 3) begin
      errors++;
      $display("FAIL early_start got %0d required 3", start_cnt);
    end
    send_sample(SW'(26), 1'b1);
    wait_start(10, w);
    checks++;
    if (w !== 2 || last_start_dlv - rst_dlv !== 8) begin
      errors++;
      $display("FAIL refill_start got %0d/%0d required 2/8", w, last_start_dlv - rst_dlv);
    end
  endtask

  task automatic test_unvoiced;
    int pv;
    send_result(32'h0000_0000, 1'b1);
    @(negedge clk);
    checks++;
    if (pitch_valid_out !== 1'b1 || voiced_out !== 1'b0 || frames_out !== 16'd3) begin
      errors++;
      $display("FAIL unvoiced got %b/%b/%0d required 1/0/3", pitch_valid_out, voiced_out, frames_out);
    end
    idle(4);
    pv = pv_cnt;
    send_result(32'h1234_5678, 1'b0);
    idle(3);
    checks++;
    if (pitch_out !== 32'h0 || frames_out !== 16'd3 || pv_cnt !== pv) begin
      errors++;
      $display("FAIL stray_result got %h/%0d/%0d required 0/3/%0d", pitch_out, frames_out, pv_cnt, pv);
    end
  endtask

  task automatic test_disable;
    int d;
    @(posedge clk); #1;
    enable_in = 1'b0;
    idle(2);
    d = dlv_cnt;
    send_sample(SW'(27), 1'b0);
    send_sample(SW'(28), 1'b0);
    idle(3);
    checks++;
    if (dlv_cnt !== d) begin
      errors++;
      $display("FAIL disabled_ignore got %0d required %0d", dlv_cnt, d);
    end
    enable_in = 1'b1;
  endtask

  task automatic test_reset_busy;
    int w;
    int pv;
    idle(2);
    for (int i = 30; i <= 33; i++) send_sample(SW'(i), 1'b1);
    wait_start(10, w);
    checks++;
    if (w !== 2) begin
      errors++;
      $display("FAIL pre_reset_start got %0d required 2", w);
    end
    send_sample(SW'(34), 1'b0);
    @(posedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({est_sig_out, est_sig_valid_out, est_start_out, est_rst_out, pitch_out,
         pitch_valid_out, voiced_out, overflow_out, timeout_out, frames_out} !== '0) begin
      errors++;
      $display("FAIL busy_reset got %h required 0",
               {est_sig_out, est_sig_valid_out, est_start_out, est_rst_out, pitch_out,
                pitch_valid_out, voiced_out, overflow_out, timeout_out, frames_out});
    end
    idle(3);
    pv = pv_cnt;
    send_result(32'h0064_0000, 1'b0);
    idle(4);
    checks++;
    if (pitch_out !== 32'h0 || frames_out !== 16'd0 || voiced_out !== 1'b0 || pv_cnt !== pv) begin
      errors++;
      $display("FAIL post_reset_result got %h/%0d/%b required 0/0/0", pitch_out, frames_out, voiced_out);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_result;
    test_overflow;
    test_timeout;
    test_unvoiced;
    test_disable;
    test_reset_busy;
    checks++;
    if (exp_q.size() !== 0 || pitch_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d required 0/0", exp_q.size(), pitch_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
